// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - control FSM for a subtractive GCD datapath
//
// Sequences operand loads from the shared data_in bus into datapath registers
// A and B, then steers the subtract/compare loop from the gt/lt/eq status until
// the registers match. An iteration watchdog aborts runs that never converge.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a run (only honoured in IDLE)
//   in_valid/in_ready operand handshake on data_in (A first, then B)
//   gt, lt, eq        datapath compare of A against B
//   ldA, ldB          register load enables (never both high)
//   sel1, sel2        subtractor minuend / subtrahend select (0 = A, 1 = B)
//   sel_in            register bus source (1 = data_in, 0 = subtractor)
//   busy              run in progress (operand load and compute phases)
//   done, err         completion / watchdog abort, held until done_ack
//   done_ack          host consumed done/err
//   iter_count        subtract cycles used by the current or last run

module gcd_controller #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             done_ack,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_CALC,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(MAX_ITER);

  state_t state, state_nxt;
  logic   cnt_clr, cnt_inc;
  logic   at_max;

  assign at_max = (iter_count == ITER_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Increment is only ever requested below ITER_MAX (CALC leaves for ERR at
  // the limit), so the counter saturates without a separate clamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_count <= '0;
    end else if (cnt_clr) begin
      iter_count <= '0;
    end else if (cnt_inc) begin
      iter_count <= iter_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ldA       = 1'b0;
    ldB       = 1'b0;
    sel1      = 1'b0;
    sel2      = 1'b0;
    sel_in    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LDA;
          cnt_clr   = 1'b1;
        end
      end

      S_LDA: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        sel_in   = 1'b1;
        ldA      = in_valid;
        if (in_valid) state_nxt = S_LDB;
      end

      S_LDB: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        sel_in   = 1'b1;
        ldB      = in_valid;
        if (in_valid) state_nxt = S_CALC;
      end

      S_CALC: begin
        busy = 1'b1;
        // eq wins even at the iteration limit: a run that converges on its
        // last permitted subtract still reports done.
        if (eq) begin
          state_nxt = S_DONE;
        end else if (at_max) begin
          state_nxt = S_ERR;
        end else begin
          // An illegal all-zero status still burns an iteration so the
          // watchdog bounds a stuck datapath.
          cnt_inc = 1'b1;
          if (gt) begin
            ldA  = 1'b1;
            sel2 = 1'b1;
          end else if (lt) begin
            ldB  = 1'b1;
            sel1 = 1'b1;
          end
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (done_ack) state_nxt = S_IDLE;
      end

      S_ERR: begin
        err = 1'b1;
        if (done_ack) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Control FSM for the subtractive GCD datapath. It sequences operand loading from the shared `data_in` bus and drives the subtract/compare loop from the datapath's `gt`/`lt`/`eq` status until the two registers are equal, then reports completion. It adds start/operand/result handshakes and an iteration watchdog for cases that never converge, such as a zero operand.

## Interface
- `CNT_W`, default 16: width of the iteration counter.
- `MAX_ITER`, default 65535: number of subtract cycles after which the run is aborted with `err`.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new GCD run; sampled only in IDLE.
- `in_valid`  in  1  `data_in` holds a valid operand this cycle.
- `in_ready`  out  1  controller accepts an operand this cycle.
- `gt`, `lt`, `eq`  in  1 each  datapath compare of A against B.
- `ldA`, `ldB`  out  1 each  load enables for datapath registers A and B.
- `sel1`  out  1  subtractor minuend: 0 selects A, 1 selects B.
- `sel2`  out  1  subtractor subtrahend: 0 selects A, 1 selects B.
- `sel_in`  out  1  register bus source: 1 selects `data_in`, 0 selects the subtractor output.
- `busy`  out  1  a run is in progress (LDA through CALC).
- `done`  out  1  result valid; A and B both hold the GCD.
- `err`  out  1  watchdog expired; contents of A and B are undefined.
- `done_ack`  in  1  host has consumed `done`/`err`.
- `iter_count`  out  `CNT_W`  subtract cycles used by the current or last run.

## Operation
- States: IDLE, LDA, LDB, CALC, DONE, ERR. Encoding is free; state register is reset asynchronously to IDLE.
- **IDLE:** all control outputs 0.
  - `start`=1 → LDA, and `iter_count` clears to 0.
- **LDA:**
  - `in_ready`=1, `sel_in`=1.
  - `ldA` = `in_valid`, combinational.
  - `in_valid`=1 → LDB; otherwise stay in LDA.
- **LDB:** same as LDA, but drives `ldB` and moves to CALC on `in_valid`.
- **CALC:** `busy`=1, `sel_in`=0. Decisions use `gt`/`lt`/`eq` in the current cycle.
  - `eq`=1 → DONE; no load.
  - `gt`=1 → `sel1`=0, `sel2`=1, `ldA`=1 (A ← A−B); `iter_count`+1.
  - `lt`=1 → `sel1`=1, `sel2`=0, `ldB`=1 (B ← B−A); `iter_count`+1.
  - `iter_count` == `MAX_ITER` while `eq`=0 → ERR; no load issued that cycle.
  - If more than one of `gt`/`lt`/`eq` is asserted, priority is `eq` > `gt` > `lt`.
  - If none is asserted (illegal), stay in CALC; the cycle counts as an iteration.
- **DONE:** `done`=1, held until `done_ack`=1, then → IDLE.
- **ERR:** `err`=1, held until `done_ack`=1, then → IDLE.
- `start` outside IDLE is ignored. There is no abort except reset.
- `done_ack` outside DONE/ERR is ignored.
- `ldA` and `ldB` are never high in the same cycle.
- `in_ready` is high only in LDA and LDB.
- `iter_count` saturates at `MAX_ITER`. It holds its value in DONE, ERR and IDLE and clears only on the cycle `start` is accepted.
- Zero-operand behaviour:
  - Both operands 0: `eq` → DONE with result 0.
  - Exactly one operand 0: `gt` or `lt` repeats without progress, so the run ends in ERR after `MAX_ITER`.

## Timing
- Reset, asynchronous: state = IDLE, `iter_count` = 0, and `busy`/`done`/`err`/`in_ready`/`ldA`/`ldB`/`sel1`/`sel2`/`sel_in` = 0 immediately.
- Release of `rst_n` is used synchronously; the first transition is possible on the first clk edge after release.
- Reset asserted mid-run returns to IDLE at once; datapath register contents are don't-care.
- Outputs are decoded from state, plus `in_valid` or status in the same cycle (Mealy for loads). There is no output register stage.
- `start` high at edge t → LDA from t+1.
- With `in_valid` held high, A loads at edge t+2 and B at edge t+3, then CALC from t+3.
- Each subtract takes one cycle; the compare on the updated registers is valid in the next cycle.
- Latency from `start` to `done`: 3 + N + 1 edges, where N = number of subtracts.
- `done`/`err` deassert on the edge after `done_ack`. A new `start` is accepted on the following cycle (IDLE).

## Test plan
- **Operands 12, 8; `in_valid` held high.**
  - `ldA` at t+1, `ldB` at t+2.
  - CALC: `gt` → `ldA` with `sel1`=0/`sel2`=1; then `lt` → `ldB` with `sel1`=1/`sel2`=0; then `eq`.
  - `done`=1 from t+6, `iter_count`=2.
- **Operand handshake stall.**
  - `in_valid` low for 3 cycles in LDA: `in_ready`=1 held, `ldA`=0 throughout.
  - `ldA` pulses exactly once when `in_valid` rises; then enter LDB.
- **Operands 65535, 1; `MAX_ITER`=65535.**
  - 65534 subtracts, then `eq` → `done`, `iter_count`=65534, `err`=0.
- **Operands 7, 0; `MAX_ITER`=16.**
  - 16 `ldA` pulses, then `err`=1, `done`=0, `iter_count`=16.
  - `done_ack` → IDLE next cycle.
- **Operands 0, 0:** `eq` on first CALC cycle → `done`, `iter_count`=0.
- **Reset and `start` hygiene.**
  - `rst_n` low mid-CALC, between edges: all outputs 0 immediately. After release, `start` runs 12, 8 correctly.
  - `start` pulsed during CALC and DONE has no effect.
